// File: rtl/dram_req_arbiter.sv
// Arbitrates NPORT requesters onto the single DRAM controller user port, one whole transaction at a time.
// Define DRAM_ARB_FIXED_PRIO_EN for fixed priority (port 0 highest) instead of round-robin.
module dram_req_arbiter #(
    parameter int NPORT   = 3,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst_x,
    input  logic [NPORT-1:0]   req_rd,
    input  logic [NPORT-1:0]   req_wr,
    input  logic [NPORT*32-1:0] req_addr,
    input  logic [NPORT*32-1:0] req_wdata,
    input  logic [NPORT*3-1:0] req_ctrl,
    output logic [NPORT-1:0]   rsp_ack,
    output logic [31:0]        rsp_data,
    output logic               m_rd_en,
    output logic               m_wr_en,
    output logic [31:0]        m_addr,
    output logic [31:0]        m_wdata,
    output logic [2:0]         m_ctrl,
    input  logic [31:0]        m_rdata,
    input  logic               m_busy,
    input  logic               m_init_done,
    output logic [1:0]         grant_id,
    output logic               busy_timeout
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [NPORT-1:0] ACK_ONE = NPORT'(1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        ACK
    } state_t;

    state_t          state;
    logic            op_rd;
    logic [CW-1:0]   wait_cnt;
    logic [NPORT-1:0] req_any;
    logic            sel_valid;
    logic [1:0]      sel_port;
    logic [31:0]     addr_arr  [NPORT];
    logic [31:0]     wdata_arr [NPORT];
    logic [2:0]      ctrl_arr  [NPORT];

    assign req_any = req_rd | req_wr;

    for (genvar p = 0; p < NPORT; p++) begin : g_unpack
        assign addr_arr[p]  = req_addr[32*p +: 32];
        assign wdata_arr[p] = req_wdata[32*p +: 32];
        assign ctrl_arr[p]  = req_ctrl[3*p +: 3];
    end

`ifdef DRAM_ARB_FIXED_PRIO_EN
    // Descending scan so the lowest-numbered requester is the last (winning) assignment.
    always_comb begin
        sel_valid = 1'b0;
        sel_port  = 2'd0;
        for (int i = NPORT - 1; i >= 0; i--) begin
            if (req_any[i]) begin
                sel_valid = 1'b1;
                sel_port  = 2'(i);
            end
        end
    end
`else
    logic [1:0] rr_ptr;
    logic [2:0] idx;

    // Scan offsets from the far end so the port nearest rr_ptr wins.
    // NOTE: every always_comb output gets a default first; a missed path would infer a latch.
    always_comb begin
        sel_valid = 1'b0;
        sel_port  = 2'd0;
        idx       = 3'd0;
        for (int i = NPORT - 1; i >= 0; i--) begin
            idx = 3'(rr_ptr) + 3'(i);
            if (idx >= 3'(NPORT)) idx = idx - 3'(NPORT);
            if (req_any[idx]) begin
                sel_valid = 1'b1;
                sel_port  = idx[1:0];
            end
        end
    end
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            state        <= IDLE;
            op_rd        <= 1'b0;
            wait_cnt     <= '0;
            rsp_ack      <= '0;
            rsp_data     <= '0;
            m_rd_en      <= 1'b0;
            m_wr_en      <= 1'b0;
            m_addr       <= '0;
            m_wdata      <= '0;
            m_ctrl       <= '0;
            grant_id     <= '0;
            busy_timeout <= 1'b0;
`ifndef DRAM_ARB_FIXED_PRIO_EN
            rr_ptr       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    rsp_ack <= '0;
                    if (m_init_done && sel_valid) begin
                        grant_id <= sel_port;
                        m_addr   <= addr_arr[sel_port];
                        m_wdata  <= wdata_arr[sel_port];
                        m_ctrl   <= ctrl_arr[sel_port];
                        op_rd    <= req_rd[sel_port];
                        // A refresh already in progress keeps the enable low until busy drops.
                        m_rd_en  <= req_rd[sel_port] & ~m_busy;
                        m_wr_en  <= ~req_rd[sel_port] & ~m_busy;
                        wait_cnt <= '0;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (m_rd_en || m_wr_en) begin
                        if (m_busy) begin
                            m_rd_en <= 1'b0;
                            m_wr_en <= 1'b0;
                            state   <= WAIT;
                        end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                            busy_timeout <= 1'b1;
                            m_rd_en      <= 1'b0;
                            m_wr_en      <= 1'b0;
                            state        <= IDLE;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end else if (!m_busy) begin
                        m_rd_en <= op_rd;
                        m_wr_en <= ~op_rd;
                    end
                end
                WAIT: begin
                    if (!m_busy) begin
                        rsp_data <= op_rd ? m_rdata : 32'd0;
                        rsp_ack  <= ACK_ONE << grant_id;
                        state    <= ACK;
                    end
                end
                ACK: begin
                    rsp_ack <= '0;
`ifndef DRAM_ARB_FIXED_PRIO_EN
                    rr_ptr  <= (grant_id == 2'(NPORT - 1)) ? 2'd0 : grant_id + 2'd1;
`endif
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dram_req_arbiter.sv
// Scoreboard bench for dram_req_arbiter with a negedge behavioural DRAM controller model.
module tb_dram_req_arbiter;

    localparam int NPORT   = 3;
    localparam int TIMEOUT = 16;

    typedef struct {
        int          port;
        bit          is_rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  ctrl;
        logic [31:0] rdata;
    } txn_t;

    logic                clk;
    logic                rst_x;
    logic [NPORT-1:0]    req_rd;
    logic [NPORT-1:0]    req_wr;
    logic [NPORT*32-1:0] req_addr;
    logic [NPORT*32-1:0] req_wdata;
    logic [NPORT*3-1:0]  req_ctrl;
    logic [NPORT-1:0]    rsp_ack;
    logic [31:0]         rsp_data;
    logic                m_rd_en;
    logic                m_wr_en;
    logic [31:0]         m_addr;
    logic [31:0]         m_wdata;
    logic [2:0]          m_ctrl;
    logic [31:0]         m_rdata = '0;
    logic                m_busy = 1'b0;
    logic                m_init_done;
    logic [1:0]          grant_id;
    logic                busy_timeout;

    txn_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   ack_cnt = 0;
    int   hold_cnt[NPORT];

    // Controller model controls (written by the test process only)
    bit   never_busy = 1'b0;
    int   busy_hold = 5;
    int   refresh_req_cnt = 0;

    // Controller model state (written by the model only)
    int   busy_left = 0;
    int   refresh_done = 0;
    int   en_cycles = 0;
    bit   in_txn = 1'b0;

    // Test-side observation history
    bit               prev_busy = 1'b0;
    bit               prev_in_txn = 1'b0;
    logic [NPORT-1:0] prev_ack = '0;
    logic [31:0]      cap_addr;
    logic [31:0]      cap_wdata;
    logic [2:0]       cap_ctrl;

    dram_req_arbiter #(.NPORT(NPORT), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst_x        (rst_x),
        .req_rd       (req_rd),
        .req_wr       (req_wr),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_ctrl     (req_ctrl),
        .rsp_ack      (rsp_ack),
        .rsp_data     (rsp_data),
        .m_rd_en      (m_rd_en),
        .m_wr_en      (m_wr_en),
        .m_addr       (m_addr),
        .m_wdata      (m_wdata),
        .m_ctrl       (m_ctrl),
        .m_rdata      (m_rdata),
        .m_busy       (m_busy),
        .m_init_done  (m_init_done),
        .grant_id     (grant_id),
        .busy_timeout (busy_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Controller: an enable seen while idle raises busy for busy_hold cycles; refresh bursts last 8.
    always @(negedge clk) begin
        if (!rst_x) begin
            busy_left    = 0;
            m_busy       = 1'b0;
            in_txn       = 1'b0;
            refresh_done = refresh_req_cnt;
        end else begin
            if (m_rd_en || m_wr_en) en_cycles++;
            if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) begin
                    m_busy = 1'b0;
                    in_txn = 1'b0;
                end
            end else if (refresh_done != refresh_req_cnt) begin
                refresh_done++;
                m_busy    = 1'b1;
                busy_left = 8;
            end else if ((m_rd_en || m_wr_en) && !never_busy) begin
                m_busy    = 1'b1;
                busy_left = busy_hold;
                in_txn    = 1'b1;
                m_rdata   = (exp_q.size() > 0) ? exp_q[0].rdata : 32'hBAD0_BAD0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic set_req(input int p, input bit rd, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [2:0] ctrl);
        req_addr[32*p +: 32]  = addr;
        req_wdata[32*p +: 32] = wdata;
        req_ctrl[3*p +: 3]    = ctrl;
        req_rd[p]             = rd;
        req_wr[p]             = ~rd;
    endtask

    task automatic push_exp(input int p, input bit rd, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [2:0] ctrl, input logic [31:0] rdata);
        txn_t t;
        t.port = p; t.is_rd = rd; t.addr = addr; t.wdata = wdata; t.ctrl = ctrl; t.rdata = rdata;
        exp_q.push_back(t);
    endtask

    task automatic drive_req(input int p, input bit rd, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [2:0] ctrl, input logic [31:0] rdata);
        push_exp(p, rd, addr, wdata, ctrl, rdata);
        set_req(p, rd, addr, wdata, ctrl);
    endtask

    // One clock of observation: issue fields, field stability, enable-under-busy, ack scoreboard.
    task automatic step();
        txn_t t;
        logic [NPORT-1:0] oh;
        @(negedge clk);
        #1;
        if (!rst_x) begin
            prev_busy = 1'b0; prev_in_txn = 1'b0; prev_ack = '0;
            return;
        end
        if (prev_busy) begin
            checks++;
            if (m_rd_en || m_wr_en) begin
                errors++;
                $display("FAIL en_during_busy: rd_en=%b wr_en=%b required 0 0", m_rd_en, m_wr_en);
            end
        end
        if (in_txn && !prev_in_txn) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_issue: addr=%h with empty scoreboard", m_addr);
            end else begin
                t = exp_q[0];
                if ({m_addr, m_wdata, m_ctrl, grant_id, m_rd_en, m_wr_en} !==
                    {t.addr, t.wdata, t.ctrl, 2'(t.port), t.is_rd, ~t.is_rd}) begin
                    errors++;
                    $display("FAIL issue: addr=%h wdata=%h ctrl=%b gid=%0d rd=%b wr=%b required addr=%h wdata=%h ctrl=%b gid=%0d rd=%b",
                             m_addr, m_wdata, m_ctrl, grant_id, m_rd_en, m_wr_en,
                             t.addr, t.wdata, t.ctrl, t.port, t.is_rd);
                end
            end
            cap_addr = m_addr; cap_wdata = m_wdata; cap_ctrl = m_ctrl;
        end else if (in_txn && prev_in_txn) begin
            checks++;
            if ({m_addr, m_wdata, m_ctrl} !== {cap_addr, cap_wdata, cap_ctrl}) begin
                errors++;
                $display("FAIL field_stable: %h/%h/%b required %h/%h/%b",
                         m_addr, m_wdata, m_ctrl, cap_addr, cap_wdata, cap_ctrl);
            end
        end
        if (prev_ack != '0) begin
            checks++;
            if (rsp_ack !== '0) begin
                errors++;
                $display("FAIL ack_width: rsp_ack=%b required 0 after one cycle", rsp_ack);
            end
        end else if (rsp_ack !== '0) begin
            ack_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ack: rsp_ack=%b with empty scoreboard", rsp_ack);
            end else begin
                t  = exp_q.pop_front();
                oh = '0;
                oh[t.port] = 1'b1;
                if ({rsp_ack, rsp_data} !== {oh, (t.is_rd ? t.rdata : 32'd0)}) begin
                    errors++;
                    $display("FAIL ack: rsp_ack=%b data=%h required %b data=%h",
                             rsp_ack, rsp_data, oh, (t.is_rd ? t.rdata : 32'd0));
                end
            end
            for (int p = 0; p < NPORT; p++) begin
                if (rsp_ack[p]) begin
                    if (hold_cnt[p] > 0) hold_cnt[p]--;
                    else begin
                        req_rd[p] = 1'b0;
                        req_wr[p] = 1'b0;
                    end
                end
            end
        end
        prev_busy   = m_busy;
        prev_in_txn = in_txn;
        prev_ack    = rsp_ack;
    endtask

    task automatic wait_ack(input int n, input int budget, input string name);
        int target = ack_cnt + n;
        int k = 0;
        while (ack_cnt < target && k < budget) begin
            step();
            k++;
        end
        checks++;
        if (ack_cnt < target) begin
            errors++;
            $display("FAIL %s: acks seen %0d required %0d", name, ack_cnt - (target - n), n);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        rst_x = 1'b0; m_init_done = 1'b0;
        req_rd = '0; req_wr = '0; req_addr = '0; req_wdata = '0; req_ctrl = '0;
        for (int p = 0; p < NPORT; p++) hold_cnt[p] = 0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({rsp_ack, rsp_data, m_rd_en, m_wr_en, m_addr, m_wdata, m_ctrl, grant_id, busy_timeout} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ack=%b data=%h rd=%b wr=%b addr=%h gid=%0d to=%b required all 0",
                     rsp_ack, rsp_data, m_rd_en, m_wr_en, m_addr, grant_id, busy_timeout);
        end
        @(negedge clk);
        rst_x = 1'b1;
    endtask

    task automatic test_init();
        int en0 = en_cycles;
        set_req(0, 1'b1, 32'h0000_0010, 32'd0, 3'b010);
        idle(4);
        req_rd[0] = 1'b0;
        drive_req(2, 1'b0, 32'h0000_2000, 32'hCAFE_F00D, 3'b010, 32'h1357_9BDF);
        idle(4);
        checks++;
        if (en_cycles != en0) begin
            errors++;
            $display("FAIL init_hold: enable cycles %0d required 0", en_cycles - en0);
        end
        m_init_done = 1'b1;
        wait_ack(1, 40, "init_release");
        idle(2);
    endtask

    task automatic test_contention();
        busy_hold   = 3;
        hold_cnt[0] = 1;
        set_req(0, 1'b1, 32'h0000_0100, 32'd0, 3'b010);
        set_req(1, 1'b1, 32'h0000_0104, 32'd0, 3'b010);
        set_req(2, 1'b1, 32'h0000_0108, 32'd0, 3'b010);
`ifdef DRAM_ARB_FIXED_PRIO_EN
        push_exp(0, 1'b1, 32'h0000_0100, 32'd0, 3'b010, 32'hA000_0000);
        push_exp(0, 1'b1, 32'h0000_0100, 32'd0, 3'b010, 32'hA000_0010);
        push_exp(1, 1'b1, 32'h0000_0104, 32'd0, 3'b010, 32'hA000_0001);
        push_exp(2, 1'b1, 32'h0000_0108, 32'd0, 3'b010, 32'hA000_0002);
`else
        push_exp(0, 1'b1, 32'h0000_0100, 32'd0, 3'b010, 32'hA000_0000);
        push_exp(1, 1'b1, 32'h0000_0104, 32'd0, 3'b010, 32'hA000_0001);
        push_exp(2, 1'b1, 32'h0000_0108, 32'd0, 3'b010, 32'hA000_0002);
        push_exp(0, 1'b1, 32'h0000_0100, 32'd0, 3'b010, 32'hA000_0010);
`endif
        wait_ack(4, 200, "contention");
        idle(3);
    endtask

    task automatic test_single_read();
        int en0 = en_cycles;
        busy_hold = 5;
        drive_req(1, 1'b1, 32'h0000_1004, 32'd0, 3'b010, 32'hDEAD_BEEF);
        wait_ack(1, 40, "single_read");
        checks++;
        if (en_cycles - en0 != 1) begin
            errors++;
            $display("FAIL single_read_en: enable cycles %0d required 1", en_cycles - en0);
        end
        idle(2);
    endtask

    task automatic test_unaligned_sw();
        int en0 = en_cycles;
        int k = 0;
        busy_hold = 14;
        drive_req(2, 1'b0, 32'h0000_0203, 32'h1122_3344, 3'b010, 32'h55AA_55AA);
        while (!in_txn && k < 10) begin step(); k++; end
        checks++;
        if (!in_txn) begin
            errors++;
            $display("FAIL sw_issue: no write issued within %0d cycles", k);
        end
        req_wr[2] = 1'b0;
        wait_ack(1, 60, "unaligned_sw");
        checks++;
        if (en_cycles - en0 != 1) begin
            errors++;
            $display("FAIL sw_episodes: enable cycles %0d required 1", en_cycles - en0);
        end
        idle(2);
    endtask

    task automatic test_refresh();
        int en0;
        int k = 0;
        busy_hold = 5;
        refresh_req_cnt++;
        while (!m_busy && k < 5) begin step(); k++; end
        en0 = en_cycles;
        drive_req(0, 1'b1, 32'h0000_0040, 32'd0, 3'b001, 32'h0000_BEEF);
        wait_ack(1, 60, "refresh");
        checks++;
        if (en_cycles - en0 != 1) begin
            errors++;
            $display("FAIL refresh_en: enable cycles %0d required 1", en_cycles - en0);
        end
        idle(2);
    endtask

    task automatic test_timeout();
        int en0 = en_cycles;
        int k = 0;
        never_busy = 1'b1;
        set_req(1, 1'b0, 32'h0000_0300, 32'h1234_5678, 3'b010);
        while (!busy_timeout && k < 60) begin step(); k++; end
        checks++;
        if (busy_timeout !== 1'b1) begin
            errors++;
            $display("FAIL timeout_flag: busy_timeout=%b required 1", busy_timeout);
        end
        checks++;
        if (en_cycles - en0 != TIMEOUT) begin
            errors++;
            $display("FAIL timeout_len: enable cycles %0d required %0d", en_cycles - en0, TIMEOUT);
        end
        req_wr[1]  = 1'b0;
        never_busy = 1'b0;
        drive_req(0, 1'b1, 32'h0000_0500, 32'd0, 3'b110, 32'h0000_00A5);
        wait_ack(1, 40, "after_timeout");
        checks++;
        if (busy_timeout !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky: busy_timeout=%b required 1", busy_timeout);
        end
        idle(2);
    endtask

    task automatic test_reset_mid_wait();
        int a0;
        int k = 0;
        busy_hold = 20;
        drive_req(2, 1'b1, 32'h0000_0600, 32'd0, 3'b010, 32'h7777_7777);
        while (!in_txn && k < 10) begin step(); k++; end
        idle(2);
        rst_x = 1'b0;
        #1;
        checks++;
        if ({rsp_ack, rsp_data, m_rd_en, m_wr_en, m_addr, m_wdata, m_ctrl, grant_id, busy_timeout} !== '0) begin
            errors++;
            $display("FAIL reset_mid_wait: ack=%b data=%h rd=%b wr=%b addr=%h gid=%0d to=%b required all 0",
                     rsp_ack, rsp_data, m_rd_en, m_wr_en, m_addr, grant_id, busy_timeout);
        end
        exp_q.delete();
        req_rd = '0;
        req_wr = '0;
        idle(3);
        @(negedge clk);
        rst_x = 1'b1;
        a0 = ack_cnt;
        idle(20);
        checks++;
        if (ack_cnt != a0) begin
            errors++;
            $display("FAIL reset_no_ack: acks %0d required 0", ack_cnt - a0);
        end
        busy_hold = 4;
        drive_req(1, 1'b1, 32'h0000_0700, 32'd0, 3'b000, 32'h0000_0042);
        wait_ack(1, 40, "post_reset");
        idle(3);
    endtask

    initial begin
        test_reset();
        test_init();
        test_contention();
        test_single_read();
        test_unaligned_sw();
        test_refresh();
        test_timeout();
        test_reset_mid_wait();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover: %0d expected transactions never acked, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
